count_sched: RTL

//  Two-client scheduler that shares one loadable up-counter between requesters.

---
 rtl/count_sched.sv | 97 +++++++++
 1 files changed

// File: rtl/count_sched.sv
// Two-client scheduler sharing one loadable up-counter that runs from the start value to all-ones.
// Define CNT_SCHED_FIXED_PRIO_EN for fixed priority (client 0 wins ties); default is round robin.
module count_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] d0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             owner,
    output logic [WIDTH-1:0] q
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state;
    logic             winner;
    logic [WIDTH-1:0] dsel;

`ifdef CNT_SCHED_FIXED_PRIO_EN
    always_comb begin
        winner = ~req0;
    end
`else
    logic rr;

    // rr names the client preferred on a tie; a lone requester always wins
    always_comb begin
        winner = (req0 && req1) ? rr : req1;
    end
`endif

    always_comb begin
        dsel = owner ? d1 : d0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            busy  <= 1'b0;
            owner <= 1'b0;
`ifndef CNT_SCHED_FIXED_PRIO_EN
            rr    <= 1'b0;
`endif
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= winner;
                        gnt0  <= ~winner;
                        gnt1  <= winner;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    q     <= dsel;
                    state <= RUN;
                end
                RUN: begin
                    if (q == '1) begin
                        done0 <= ~owner;
                        done1 <= owner;
                        state <= DONE;
                    end else begin
                        q <= q + 1'b1;
                    end
                end
                DONE: begin
`ifndef CNT_SCHED_FIXED_PRIO_EN
                    rr    <= ~owner;
`endif
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
